usb_tx_packet_controller: RTL

- Device-side packet sequencer in front of usb_transceiver.
- Accepts a packet request (PID, plus an optional payload stream) from the SIE/endpoint logic.
- Drives tx_data/tx_valid byte by byte, appends CRC16 on DATA packets, and holds off transmission until the bus has been idle for a turnaround gap after rx_active.
- Reports completion or error per packet.

---
 rtl/usb_tx_packet_controller_pkg.sv | 42 ++++
 rtl/usb_crc16.sv | 42 ++++
 rtl/usb_tx_packet_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_packet_controller_pkg.sv
// Shared PID encodings, CRC16 constants and FSM state type for the USB
// device-side transmit path.
package usb_tx_packet_controller_pkg;

    typedef enum logic [3:0] {
        OUT   = 4'b0001,
        IN    = 4'b1001,
        SETUP = 4'b1101,
        DATA0 = 4'b0011,
        DATA1 = 4'b1011,
        ACK   = 4'b0010,
        NAK   = 4'b1010,
        STALL = 4'b1110
    } pid_t;

    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_PID,
        ST_PAYLOAD,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_END
    } tx_state_t;

    // PID byte on the wire: check nibble (complement) in the upper half.
    function automatic logic [7:0] pid_byte(pid_t pid);
        return {~pid, pid};
    endfunction

    function automatic logic pid_is_handshake(logic [3:0] pid);
        return (pid == ACK) || (pid == NAK) || (pid == STALL);
    endfunction

    function automatic logic pid_is_data(logic [3:0] pid);
        return (pid == DATA0) || (pid == DATA1);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 register (reflected poly, LSB first) with synchronous
// clear and per-byte enable; shared by the TX sequencer and the RX checker.
module usb_crc16
    import usb_tx_packet_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] step;

    always_comb begin
        step = crc_q ^ {8'h00, data_i};
        for (int i = 0; i < 8; i++) begin
            step = step[0] ? ((step >> 1) ^ CRC16_POLY) : (step >> 1);
        end

        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            crc_d = step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_packet_controller.sv
// Device-side USB packet sequencer: waits out the bus turnaround gap, then
// streams PID, payload and complemented CRC16 to the transceiver byte by byte.
module usb_tx_packet_controller
    import usb_tx_packet_controller_pkg::*;
#(
    parameter int MAX_LEN    = 8,
    parameter int GAP_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_pid,
    output logic       req_ready,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    input  logic       pl_last,
    input  logic       pl_empty,
    output logic       pl_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       rx_active,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);

    tx_state_t        state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic             empty_q, empty_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             ovl_q, ovl_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             req_ready_c;
    logic             pl_ready_c;
    logic             take_byte;
    logic             crc_clear;
    logic             crc_en;
    logic [15:0]      crc;

    usb_crc16 u_crc16 (
        .clk     (clk),
        .reset   (reset),
        .clear_i (crc_clear),
        .en_i    (crc_en),
        .data_i  (pl_data),
        .crc_o   (crc)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        pid_d       = pid_q;
        empty_d     = empty_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        ovl_d       = ovl_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        req_ready_c = 1'b0;
        pl_ready_c  = 1'b0;
        take_byte   = 1'b0;
        crc_clear   = 1'b0;
        crc_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                if (req_valid) begin
                    pid_d     = req_pid;
                    empty_d   = pl_empty;
                    gap_d     = '0;
                    cnt_d     = '0;
                    last_d    = 1'b0;
                    ovl_d     = 1'b0;
                    crc_clear = 1'b1;
                    if (pid_is_handshake(req_pid) || pid_is_data(req_pid)) begin
                        state_d = ST_GAP;
                    end else begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end

            // Turnaround: any receiver activity restarts the idle count.
            ST_GAP: begin
                if (rx_active) begin
                    gap_d = '0;
                end else if (gap_q == GAP_MAX) begin
                    tx_data_d  = pid_byte(pid_t'(pid_q));
                    tx_valid_d = 1'b1;
                    state_d    = ST_PID;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_PID: begin
                if (tx_ready) begin
                    if (pid_is_handshake(pid_q)) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_END;
                    end else if (empty_q) begin
                        tx_data_d = ~crc[7:0];
                        state_d   = ST_CRC_LO;
                    end else begin
                        take_byte = 1'b1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (tx_ready) begin
                    if (last_q || (cnt_q == CNT_MAX)) begin
                        tx_data_d = ~crc[7:0];
                        ovl_d     = ~last_q;
                        state_d   = ST_CRC_LO;
                    end else begin
                        take_byte = 1'b1;
                    end
                end
            end

            ST_CRC_LO: begin
                if (tx_ready) begin
                    tx_data_d = ~crc[15:8];
                    state_d   = ST_CRC_HI;
                end
            end

            ST_CRC_HI: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    error_d    = ovl_q;
                    state_d    = ST_END;
                end
            end

            ST_END: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A payload byte is owed to the transceiver; missing data truncates the packet.
        if (take_byte) begin
            if (pl_valid) begin
                pl_ready_c = 1'b1;
                tx_data_d  = pl_data;
                crc_en     = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                last_d     = pl_last;
                state_d    = ST_PAYLOAD;
            end else begin
                tx_valid_d = 1'b0;
                done_d     = 1'b1;
                error_d    = 1'b1;
                state_d    = ST_IDLE;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pid_q      <= 4'h0;
            empty_q    <= 1'b0;
            gap_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            ovl_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            empty_q    <= empty_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ovl_q      <= ovl_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // A cycle with reset high is discarded, so never advertise a handshake in it.
    assign req_ready = req_ready_c & ~reset;
    assign pl_ready  = pl_ready_c & ~reset;
    assign busy      = (state_q != ST_IDLE) & ~reset;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
